inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Program-counter / fetch stage directly upstream of the control decoder. Drives ProgCtr into
//  the instruction ROM, whose 9-bit word feeds the decoder; consumes the decoder's jump_en and
//  5-bit immediate to redirect fetch through a writable jump-target LUT. Also owns the
//  Start/Done program handshake and a run-cycle counter.
// PARAMETERS
//  PC_W       10   program-counter width; ProgCtr wraps modulo 2**PC_W
//  START_ADDR 0    PC value loaded while Start is asserted
//  LUT_DEPTH  32   jump-target LUT entries; indexed by the 5-bit immediate
//  CNT_W      16   width of cycle_count
// PORTS
//  CLK          in   1      clock; all state updates on rising edge
//  Reset        in   1      synchronous, active-high reset
//  Start        in   1      program start/re-arm request (level)
//  halt_req     in   1      end-of-program indication from decode
//  stall        in   1      hold PC this cycle
//  jump_en      in   1      taken jump/branch from the control decoder
//  jump_idx     in   5      LUT index (the decoder's immediate field)
//  lut_we       in   1      LUT write strobe
//  lut_waddr    in   5      LUT write index
//  lut_wdata    in   PC_W   LUT write data (absolute target address)
//  ProgCtr      out  PC_W   instruction ROM address
//  running      out  1      high in RUN
//  Done         out  1      high in HALTED
//  cycle_count  out  CNT_W  cycles spent in RUN, saturating
// BEHAVIOUR
//  Reset (synchronous, active-high): state=IDLE, ProgCtr=0, Done=0, running=0,
//   cycle_count=0, all LUT entries=0. Reset overrides every other input.
//  States: IDLE, ARMED, RUN, HALTED (registered; outputs decoded from state).
//   Any state, Start=1    -> ARMED; ProgCtr<=START_ADDR; cycle_count<=0; Done<=0.
//   ARMED, Start=0        -> RUN; ProgCtr holds START_ADDR (first fetch = START_ADDR).
//   RUN priority, evaluated in order when Start=0:
//     halt_req -> HALTED, ProgCtr holds (halt wins over stall and jump_en in the same cycle);
//     stall    -> ProgCtr holds; jump_en is ignored and not queued;
//     jump_en  -> ProgCtr <= LUT[jump_idx];
//     else     -> ProgCtr <= ProgCtr+1, modulo 2**PC_W (all-ones wraps to 0, no flag).
//   HALTED: ProgCtr frozen, Done=1 until Start. IDLE: ProgCtr holds, no count.
//  Latency: one cycle from jump_en/halt_req sampled to ProgCtr/state change; no bubbles.
//  cycle_count: +1 on every cycle spent in RUN (stall cycles included); saturates at
//   all-ones; cleared only on Reset or entry to ARMED.
//  LUT: write on lut_we at the clock edge, in any state. Read is combinational from the
//   current array, so a same-cycle write and jump to the same index uses the OLD entry;
//   the new value is visible on the following cycle.
//  Inputs other than Start, Reset and the LUT write port are don't-care outside RUN.
// STRUCTURE
//  Package definitions: fetch_state_t enum {IDLE,ARMED,RUN,HALTED}; kLUT_DEPTH=32;
//   kJUMP_IDX_W=5.
//  Sub-module jump_target_lut: LUT_DEPTH x PC_W array, sync write, async read, sync reset.
//  This module holds the FSM, the PC register with next-PC mux, and the counter.
// TESTING
//  1 Reset; Start=1 for 2 cycles then 0 -> ProgCtr=0 in ARMED; RUN next cycle; ProgCtr
//    then 0,1,2,3 on successive cycles; running=1.
//  2 LUT[7]=0x12A; in RUN at PC=5 assert jump_en, jump_idx=7 -> ProgCtr=0x12A next
//    cycle, then 0x12B.
//  3 At PC=9, stall=1 and jump_en=1 for one cycle -> PC stays 9, jump dropped, then 10.
//  4 halt_req=1 with jump_en=1 at PC=20 -> HALTED, Done=1, PC frozen at 20;
//    cycle_count frozen; Start pulse -> Done=0, PC=START_ADDR, cycle_count=0.
//  5 PC_W=10: free-run to 0x3FF -> next 0x000; separate run: lut_we to LUT[3]=0x050
//    in the same cycle as jump_idx=3 with old LUT[3]=0x010 -> PC=0x010.
//  6 Reset asserted mid-RUN at PC=0x0AB -> next cycle IDLE, PC=0, Done=0, cycle_count=0,
//    LUT entries read 0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding and jump-LUT geometry.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam int kLUT_DEPTH  = 32;
    localparam int kJUMP_IDX_W = 5;

endpackage

// File: rtl/inst_fetch_unit_jump_target_lut.sv
// Writable jump-target table: synchronous write, combinational read, synchronous clear.
module jump_target_lut
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH  = kLUT_DEPTH,
    parameter int DATA_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [kJUMP_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [kJUMP_IDX_W-1:0] raddr,
    output logic [DATA_W-1:0]      rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is cleared on reset so jumps through unwritten entries land at 0;
    // that forces flops rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write to the jumped index returns the old value.
    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: Start/Done FSM, program counter with jump redirect through a LUT, run-cycle counter.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int LUT_DEPTH  = kLUT_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   halt_req,
    input  logic                   stall,
    input  logic                   jump_en,
    input  logic [kJUMP_IDX_W-1:0] jump_idx,
    input  logic                   lut_we,
    input  logic [kJUMP_IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]        lut_wdata,
    output logic [PC_W-1:0]        ProgCtr,
    output logic                   running,
    output logic                   Done,
    output logic [CNT_W-1:0]       cycle_count
);

    localparam logic [PC_W-1:0] kSTART_PC = PC_W'(START_ADDR);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] jump_target;

    jump_target_lut #(
        .DEPTH  (LUT_DEPTH),
        .DATA_W (PC_W)
    ) u_lut (
        .clk   (CLK),
        .reset (Reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (jump_idx),
        .rdata (jump_target)
    );

    // NOTE: every register uses non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
        end else begin
            state   <= state_next;
            ProgCtr <= pc_next;
        end
    end

    // NOTE: defaults come first so every path assigns both signals and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = ProgCtr;
        if (Start) begin
            state_next = ARMED;
            pc_next    = kSTART_PC;
        end else begin
            unique case (state)
                IDLE:   ;
                ARMED:  state_next = RUN;
                RUN: begin
                    if (halt_req) begin
                        state_next = HALTED;
                    end else if (stall) begin
                        pc_next = ProgCtr;
                    end else if (jump_en) begin
                        pc_next = jump_target;
                    end else begin
                        pc_next = ProgCtr + 1'b1;
                    end
                end
                HALTED: ;
                default: state_next = IDLE;
            endcase
        end
    end

    // Counts every cycle spent in RUN, stalls included; Start clears it on the way into ARMED.
    always_ff @(posedge CLK) begin
        if (Reset || Start) begin
            cycle_count <= '0;
        end else if (state == RUN && cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end

    assign running = (state == RUN);
    assign Done    = (state == HALTED);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with hand-computed expected values.
module tb_inst_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        halt_req;
    logic        stall;
    logic        jump_en;
    logic [4:0]  jump_idx;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic [9:0]  ProgCtr;
    logic        running;
    logic        Done;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_fails  = 0;

    inst_fetch_unit #(
        .PC_W       (10),
        .START_ADDR (0),
        .LUT_DEPTH  (32),
        .CNT_W      (16)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Start       (Start),
        .halt_req    (halt_req),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_idx    (jump_idx),
        .lut_we      (lut_we),
        .lut_waddr   (lut_waddr),
        .lut_wdata   (lut_wdata),
        .ProgCtr     (ProgCtr),
        .running     (running),
        .Done        (Done),
        .cycle_count (cycle_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; halt_req = 1'b0; stall = 1'b0; jump_en = 1'b0;
        jump_idx = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        tick(); tick();
        check("rst_pc", 32'(ProgCtr), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        check("rst_count", 32'(cycle_count), 32'h0);

        // Reset still wins over Start
        Start = 1'b1;
        tick();
        check("rst_over_start", 32'(dut.state), 32'(inst_fetch_unit_pkg::IDLE));
        Reset = 1'b0; Start = 1'b0;
        tick();
        check("idle_hold", 32'(running), 32'h0);

        // 1: start sequence and sequential fetch
        Start = 1'b1;
        tick(); tick();
        check("armed_pc", 32'(ProgCtr), 32'h0);
        check("armed_running", 32'(running), 32'h0);
        Start = 1'b0;
        tick();
        check("run_pc0", 32'(ProgCtr), 32'h0);
        check("run_running", 32'(running), 32'h1);
        check("run_count0", 32'(cycle_count), 32'h0);
        tick(); check("run_pc1", 32'(ProgCtr), 32'h1);
        tick(); check("run_pc2", 32'(ProgCtr), 32'h2);
        tick(); check("run_pc3", 32'(ProgCtr), 32'h3);
        check("run_count3", 32'(cycle_count), 32'h3);

        // 2: LUT[7]=0x12A, jump at PC=5
        lut_we = 1'b1; lut_waddr = 5'd7; lut_wdata = 10'h12A;
        tick(); check("pc4", 32'(ProgCtr), 32'h4);
        lut_we = 1'b0;
        tick(); check("pc5", 32'(ProgCtr), 32'h5);
        jump_en = 1'b1; jump_idx = 5'd7;
        tick(); check("jump_12a", 32'(ProgCtr), 32'h12A);
        jump_en = 1'b0;
        lut_we = 1'b1; lut_waddr = 5'd1; lut_wdata = 10'd9;
        tick(); check("jump_12b", 32'(ProgCtr), 32'h12B);
        check("count7", 32'(cycle_count), 32'd7);

        // 3: stall beats jump at PC=9, jump is dropped
        lut_we = 1'b0; jump_en = 1'b1; jump_idx = 5'd1;
        tick(); check("jump_9", 32'(ProgCtr), 32'd9);
        stall = 1'b1; jump_en = 1'b1; jump_idx = 5'd7;
        tick(); check("stall_hold", 32'(ProgCtr), 32'd9);
        stall = 1'b0; jump_en = 1'b0;
        tick(); check("after_stall", 32'(ProgCtr), 32'd10);

        // 4: halt wins over jump at PC=20, then re-arm
        lut_we = 1'b1; lut_waddr = 5'd2; lut_wdata = 10'd20;
        tick(); check("pc11", 32'(ProgCtr), 32'd11);
        lut_we = 1'b0; jump_en = 1'b1; jump_idx = 5'd2;
        tick(); check("jump_20", 32'(ProgCtr), 32'd20);
        check("count12", 32'(cycle_count), 32'd12);
        halt_req = 1'b1; jump_en = 1'b1; jump_idx = 5'd7;
        tick();
        check("halt_pc", 32'(ProgCtr), 32'd20);
        check("halt_done", 32'(Done), 32'h1);
        check("halt_running", 32'(running), 32'h0);
        check("halt_count", 32'(cycle_count), 32'd13);
        halt_req = 1'b0; jump_en = 1'b0;
        tick(); tick();
        check("halted_pc", 32'(ProgCtr), 32'd20);
        check("halted_count", 32'(cycle_count), 32'd13);
        check("halted_done", 32'(Done), 32'h1);
        Start = 1'b1;
        tick();
        check("rearm_done", 32'(Done), 32'h0);
        check("rearm_pc", 32'(ProgCtr), 32'h0);
        check("rearm_count", 32'(cycle_count), 32'h0);
        Start = 1'b0;
        tick(); check("rerun_pc0", 32'(ProgCtr), 32'h0);

        // 5: wrap at all-ones, then same-cycle LUT write/read
        lut_we = 1'b1; lut_waddr = 5'd4; lut_wdata = 10'h3FE;
        tick(); check("wrap_pc1", 32'(ProgCtr), 32'h1);
        lut_we = 1'b0; jump_en = 1'b1; jump_idx = 5'd4;
        tick(); check("wrap_3fe", 32'(ProgCtr), 32'h3FE);
        jump_en = 1'b0;
        tick(); check("wrap_3ff", 32'(ProgCtr), 32'h3FF);
        tick(); check("wrap_000", 32'(ProgCtr), 32'h000);
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'h010;
        tick(); check("old_setup", 32'(ProgCtr), 32'h001);
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'h050; jump_en = 1'b1; jump_idx = 5'd3;
        tick(); check("rw_old", 32'(ProgCtr), 32'h010);
        lut_we = 1'b0;
        tick(); check("rw_new", 32'(ProgCtr), 32'h050);
        jump_en = 1'b0;
        lut_we = 1'b1; lut_waddr = 5'd5; lut_wdata = 10'h0AB;
        tick(); check("pc_051", 32'(ProgCtr), 32'h051);

        // 6: reset mid-run at 0x0AB clears everything including the LUT
        lut_we = 1'b0; jump_en = 1'b1; jump_idx = 5'd5;
        tick(); check("jump_0ab", 32'(ProgCtr), 32'h0AB);
        jump_en = 1'b0; Reset = 1'b1;
        tick();
        check("mid_rst_pc", 32'(ProgCtr), 32'h0);
        check("mid_rst_running", 32'(running), 32'h0);
        check("mid_rst_done", 32'(Done), 32'h0);
        check("mid_rst_count", 32'(cycle_count), 32'h0);
        Reset = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); check("post_rst_run", 32'(running), 32'h1);
        jump_en = 1'b1; jump_idx = 5'd5;
        tick(); check("lut5_cleared", 32'(ProgCtr), 32'h0);
        jump_idx = 5'd7;
        tick(); check("lut7_cleared", 32'(ProgCtr), 32'h0);
        jump_en = 1'b0;
        tick(); check("post_rst_inc", 32'(ProgCtr), 32'h1);
        check("post_rst_count", 32'(cycle_count), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
